mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
// - Memory-side counterpart of the CPU memory register: runs one read or write on the
//   external 16-bit synchronous RAM per control-unit request.
// - Reads: returns data on mr_data with a one-cycle mr_load strobe that drives the
//   memory register's load control (C9). Writes: drive wdata into RAM.
// - Sits between the control unit and the RAM, with a programmable number of wait states.
// PARAMETERS
// - ADDR_W    8   RAM address width
// - DATA_W    16  data width; mr_neg is taken from bit DATA_W-1
// - WAIT_CYC  2   extra access cycles inserted before the transfer cycle (0..15)
// PORTS
// - clk       in   1       system clock; all state updates on the falling edge
// - rst       in   1       reset, asynchronous, active-low
// - req       in   1       start request; sampled only in IDLE
// - we        in   1       1 = write, 0 = read; captured with req
// - addr      in   ADDR_W  access address; captured with req
// - wdata     in   DATA_W  write data; captured with req
// - busy      out  1       high from ADDR through DONE
// - done      out  1       one-cycle pulse in DONE, for reads and writes
// - mr_data   out  DATA_W  read data held until the next read completes
// - mr_load   out  1       one-cycle pulse in DONE, reads only
// - mr_neg    out  1       mr_data[DATA_W-1]
// - ram_en    out  1       RAM enable, high in ADDR/WAIT/XFER
// - ram_we    out  1       RAM write strobe, high in XFER of a write only
// - ram_addr  out  ADDR_W  latched address
// - ram_din   out  DATA_W  latched write data
// - ram_dout  in   DATA_W  RAM read data, valid in XFER
// BEHAVIOUR
// - FSM: IDLE -> ADDR -> WAIT (WAIT_CYC cycles, skipped when 0) -> XFER -> DONE -> IDLE.
// - IDLE: when req=1 at a falling edge, latch we/addr/wdata and go to ADDR.
//   When req=0, stay in IDLE.
// - ADDR: ram_en=1 and the address is stable. Next state is WAIT, or XFER if WAIT_CYC=0.
// - WAIT: a 4-bit counter loads WAIT_CYC-1 on entry and decrements.
//   Go to XFER on the edge where it reads 0.
// - XFER, read: capture ram_dout into mr_data on the exit edge.
// - XFER, write: ram_we=1 for exactly this cycle; mr_data is unchanged.
// - DONE: done=1. mr_load=1 if the access is a read. Return to IDLE on the next edge.
// - Latency: acceptance edge E0 -> DONE after edge E(2+WAIT_CYC).
//   With the default, done is high 4 cycles after acceptance.
// - req while busy: ignored, not queued. A new request is accepted in IDLE only,
//   so back-to-back accesses take 1 idle cycle between them.
// - we/addr/wdata changes while busy: no effect, because the latched copies are used.
// - Reset values: IDLE; busy, done, mr_load, ram_en, ram_we = 0;
//   mr_data, ram_addr, ram_din, counter = 0.
// - Reset mid-operation: asynchronous return to IDLE. ram_we/ram_en drop immediately,
//   no done or mr_load pulse is issued, and mr_data is cleared.
// - mr_neg is combinational from mr_data; it is 0 after reset.
// STRUCTURE
// - Shared package: FSM state encoding (IDLE=0, ADDR=1, WAIT=2, XFER=3, DONE=4)
//   and DATA_W/ADDR_W defaults shared with the memory register and the control unit.
// - One sub-module: mem_wait_cnt, the loadable 4-bit down-counter with zero flag.
// - Everything else is in one always block on the falling edge plus decoded outputs.
// TESTING
// - Reset then idle: rst=0 then 1 -> all outputs 0, busy=0, no ram_en for 10 cycles.
// - Read, WAIT_CYC=2: addr=8'h12, RAM[12]=16'h8001, req pulse ->
//   ram_en for 4 cycles, then done=mr_load=1 for 1 cycle, mr_data=16'h8001, mr_neg=1.
// - Write: we=1, addr=8'h34, wdata=16'h00A5 -> ram_we high exactly 1 cycle with
//   ram_din=16'h00A5; done pulses, mr_load stays 0, mr_data unchanged.
// - req held high plus addr changed while busy -> second access starts only after DONE->IDLE
//   and uses the address present at its own acceptance edge.
// - WAIT_CYC=0 build: read -> done 2 cycles after acceptance, WAIT state never entered.
// - rst low during WAIT of a write -> ram_we never asserts, busy=0 at once,
//   no done pulse, next req is served normally.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller, the memory register and the control unit.
// Holds the FSM state encoding, default bus widths and the wait-counter load helper.
package mem_bus_ctrl_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_XFER = 3'd3,
    ST_DONE = 3'd4
  } mem_state_t;

  // The counter reaches zero on the last wait cycle, so it starts one below the count.
  function automatic logic [CNT_W-1:0] wait_load(input int wc);
    return (wc > 0) ? CNT_W'(wc - 1) : '0;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag, timing the wait states of a RAM access.
// Updates on the falling edge like the rest of the memory bus controller.
module mem_wait_cnt
  import mem_bus_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side controller: runs one read or write on the external synchronous RAM per request,
// with WAIT_CYC programmable wait states, and feeds read data to the memory register.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mr_data,
  output logic              mr_load,
  output logic              mr_neg,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYC);

  mem_state_t       state;
  logic             we_l;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_zero;

  mem_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_ADDR),
    .load_val (WAIT_LOAD),
    .dec      (state == ST_WAIT),
    .cnt      (wait_cnt),
    .zero     (wait_zero)
  );

  // Request fields are latched at acceptance so the CPU side may change them while busy.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      we_l     <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      mr_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_l     <= we;
            ram_addr <= addr;
            ram_din  <= wdata;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: state <= (WAIT_CYC == 0) ? ST_XFER : ST_WAIT;
        ST_WAIT: if (wait_zero) state <= ST_XFER;
        ST_XFER: begin
          if (!we_l) mr_data <= ram_dout;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign mr_load = (state == ST_DONE) && !we_l;
  assign ram_en  = (state == ST_ADDR) || (state == ST_WAIT) || (state == ST_XFER);
  assign ram_we  = (state == ST_XFER) && we_l;
  assign mr_neg  = mr_data[DATA_W-1];

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed accesses against a behavioural RAM, with a scoreboard
// monitor checking each done pulse, plus a second instance built with no wait states.
module tb_mem_bus_ctrl;

  typedef struct {
    logic        rd;
    logic [15:0] data;
    logic [7:0]  addr;
    logic [15:0] din;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [7:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        busy, done, mr_load, mr_neg, ram_en, ram_we;
  logic [15:0] mr_data, ram_din, ram_dout;
  logic [7:0]  ram_addr;

  logic        req0 = 1'b0;
  logic [7:0]  addr0 = '0;
  logic        busy0, done0, mr_load0, mr_neg0, ram_en0, ram_we0;
  logic [15:0] mr_data0, ram_din0, ram_dout0;
  logic [7:0]  ram_addr0;

  logic [15:0] mem [256];
  exp_t        q[$];
  exp_t        mon_e;
  int          vectors = 0, miscompares = 0;
  int          en_cnt = 0, we_cnt = 0;
  logic [7:0]  seen_addr = '0;
  logic [15:0] seen_din = '0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .mr_data(mr_data), .mr_load(mr_load), .mr_neg(mr_neg),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  mem_bus_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(1'b0), .addr(addr0), .wdata(16'h0000),
    .busy(busy0), .done(done0), .mr_data(mr_data0), .mr_load(mr_load0), .mr_neg(mr_neg0),
    .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_din(ram_din0),
    .ram_dout(ram_dout0)
  );

  assign ram_dout  = mem[ram_addr];
  assign ram_dout0 = mem[ram_addr0];

  always @(negedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse pops one expected access.
  always @(posedge clk) begin
    if (!rst) begin
      en_cnt = 0;
      we_cnt = 0;
    end else begin
      if (ram_en) begin en_cnt++; seen_addr = ram_addr; end
      if (ram_we) begin we_cnt++; seen_din = ram_din; end
      if (done) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1, expected no pending access");
        end else begin
          mon_e = q.pop_front();
          chk("mr_load", {31'b0, mr_load}, {31'b0, mon_e.rd});
          chk("mr_data", {16'b0, mr_data}, {16'b0, mon_e.data});
          chk("mr_neg", {31'b0, mr_neg}, {31'b0, mon_e.data[15]});
          chk("ram_en_cycles", en_cnt, 4);
          chk("ram_we_cycles", we_cnt, mon_e.rd ? 0 : 1);
          chk("ram_addr", {24'b0, seen_addr}, {24'b0, mon_e.addr});
          if (!mon_e.rd) chk("ram_din", {16'b0, seen_din}, {16'b0, mon_e.din});
        end
        en_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic push(input logic rd, input logic [15:0] data, input logic [7:0] a,
                      input logic [15:0] din);
    exp_t e;
    e.rd = rd; e.data = data; e.addr = a; e.din = din;
    q.push_back(e);
  endtask

  task automatic start(input logic w, input logic [7:0] a, input logic [15:0] d);
    @(posedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n, gap, en;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h12] = 16'h8001;
    mem[8'h20] = 16'h1234;
    mem[8'h21] = 16'h7FFF;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_ctrl", {27'b0, busy, done, mr_load, ram_en, ram_we}, 32'd0);
    chk("rst_mr_data", {16'b0, mr_data}, 32'd0);
    chk("rst_mr_neg", {31'b0, mr_neg}, 32'd0);
    chk("rst_ram_addr", {24'b0, ram_addr}, 32'd0);
    chk("rst_ram_din", {16'b0, ram_din}, 32'd0);
    repeat (2) @(posedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(posedge clk);
      chk("idle_quiet", {29'b0, busy, ram_en, done}, 32'd0);
    end

    // Read with two wait states
    push(1'b1, 16'h8001, 8'h12, 16'h0000);
    start(1'b0, 8'h12, 16'h0000);
    wait_idle();

    // Write; wdata changed while busy must not matter
    push(1'b0, 16'h8001, 8'h34, 16'h00A5);
    start(1'b1, 8'h34, 16'h00A5);
    wdata = 16'hFFFF;
    wait_idle();
    @(posedge clk);
    chk("ram_written", {16'b0, mem[8'h34]}, 32'h00A5);

    // req held high, address changed while busy
    push(1'b1, 16'h1234, 8'h20, 16'h0000);
    push(1'b1, 16'h7FFF, 8'h21, 16'h0000);
    @(posedge clk);
    req = 1'b1; we = 1'b0; addr = 8'h20;
    @(posedge clk);
    addr = 8'h21;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); n++; end
    chk("held_first_done_lat", n, 4);
    gap = 0;
    @(posedge clk);
    while (!busy && gap < 20) begin gap++; @(posedge clk); end
    chk("idle_gap", gap, 1);
    req = 1'b0;
    wait_idle();

    // Reset during the wait states of a write
    start(1'b1, 8'h40, 16'hBEEF);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ctrl", {27'b0, busy, done, mr_load, ram_en, ram_we}, 32'd0);
    chk("midrst_mr_data", {16'b0, mr_data}, 32'd0);
    repeat (2) @(posedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    chk("midrst_no_write", {16'b0, mem[8'h40]}, 32'd0);
    push(1'b1, 16'h8001, 8'h12, 16'h0000);
    start(1'b0, 8'h12, 16'h0000);
    wait_idle();

    // No-wait-state build
    @(posedge clk);
    req0 = 1'b1; addr0 = 8'h12;
    @(posedge clk);
    req0 = 1'b0;
    chk("nw_busy", {31'b0, busy0}, 32'd1);
    n = 0;
    en = ram_en0 ? 1 : 0;
    while (!done0 && n < 10) begin
      @(posedge clk);
      n++;
      if (ram_en0) en++;
    end
    chk("nw_done_lat", n, 2);
    chk("nw_en_cycles", en, 2);
    chk("nw_mr_load", {31'b0, mr_load0}, 32'd1);
    chk("nw_mr_data", {16'b0, mr_data0}, 32'h8001);
    chk("nw_mr_neg", {31'b0, mr_neg0}, 32'd1);
    repeat (3) @(posedge clk);

    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
